// File: rtl/uart_rx.sv
// 8N1 UART receiver on an 8x oversample tick, centre-sampled, LSB first.
// Define PARITY_EN to add an even-parity bit before the stop bit (pe flag).
module uart_rx (
  input  logic       fclk,
  input  logic       rst,
  input  logic       bclkx8,
  input  logic       rxd,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       rdrf,
  output logic       fe,
  output logic       oe,
  output logic       pe
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t     state_q, state_d;
  logic       sync1_q, rxd_s_q;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] dout_q, dout_d;
  logic       rdrf_q, rdrf_d;
  logic       fe_q, fe_d;
  logic       oe_q, oe_d;
  logic       load;
`ifdef PARITY_EN
  logic       pe_q, pe_d;
  logic       pe_nxt_q, pe_nxt_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    dout_d   = dout_q;
    rdrf_d   = rdrf_q;
    fe_d     = fe_q;
    oe_d     = oe_q;
    load     = 1'b0;
`ifdef PARITY_EN
    pe_d     = pe_q;
    pe_nxt_d = pe_nxt_q;
`endif

    if (bclkx8) begin
      case (state_q)
        IDLE: begin
          if (!rxd_s_q) begin
            state_d = START;
            cnt_d   = 3'd0;
          end
        end
        START: begin
          cnt_d = cnt_q + 3'd1;
          // cnt reaches 3 on this tick: middle of the start bit
          if (cnt_q == 3'd2) begin
            if (!rxd_s_q) begin
              state_d  = DATA;
              cnt_d    = 3'd0;
              bitcnt_d = 3'd0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            sr_d     = {rxd_s_q, sr_q[7:1]};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
`ifdef PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            pe_nxt_d = (^sr_q) ^ rxd_s_q;
            state_d  = STOP;
          end
        end
`endif
        STOP: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            load    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (rd && rdrf_q) begin
      rdrf_d = 1'b0;
      fe_d   = 1'b0;
      oe_d   = 1'b0;
`ifdef PARITY_EN
      pe_d   = 1'b0;
`endif
    end

    // A read in the load cycle frees the register for the new byte
    if (load) begin
      if (!rdrf_q || rd) begin
        dout_d = sr_q;
        rdrf_d = 1'b1;
        fe_d   = ~rxd_s_q;
`ifdef PARITY_EN
        pe_d   = pe_nxt_q;
`endif
      end else begin
        oe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      rxd_s_q  <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      bitcnt_q <= 3'd0;
      sr_q     <= 8'h00;
      dout_q   <= 8'h00;
      rdrf_q   <= 1'b0;
      fe_q     <= 1'b0;
      oe_q     <= 1'b0;
    end else begin
      sync1_q  <= rxd;
      rxd_s_q  <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      sr_q     <= sr_d;
      dout_q   <= dout_d;
      rdrf_q   <= rdrf_d;
      fe_q     <= fe_d;
      oe_q     <= oe_d;
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      pe_q     <= 1'b0;
      pe_nxt_q <= 1'b0;
    end else begin
      pe_q     <= pe_d;
      pe_nxt_q <= pe_nxt_d;
    end
  end

  assign pe = pe_q;
`else
  assign pe = 1'b0;
`endif

  assign dout = dout_q;
  assign rdrf = rdrf_q;
  assign fe   = fe_q;
  assign oe   = oe_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven at exactly 8 ticks/bit, tick every other fclk.
// Honours PARITY_EN to send the parity bit and run the parity cases.
module tb_uart_rx;

`ifdef PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Frame starts at negedge N0 with a tick on the following posedge; the stop
  // sample (and load) lands on posedge 152 (+16 with parity) after that.
  localparam int LOAD_OFS    = 152 + 16 * PAR_BITS;
  localparam int FRAME_CYCLS = 16 * (10 + PAR_BITS);

  logic       fclk   = 1'b0;
  logic       rst    = 1'b1;
  logic       bclkx8 = 1'b0;
  logic       rxd    = 1'b1;
  logic       rd     = 1'b0;
  logic [7:0] dout;
  logic       rdrf, fe, oe, pe;

  int n_checks = 0;
  int n_errors = 0;

  uart_rx dut (
    .fclk   (fclk),
    .rst    (rst),
    .bclkx8 (bclkx8),
    .rxd    (rxd),
    .rd     (rd),
    .dout   (dout),
    .rdrf   (rdrf),
    .fe     (fe),
    .oe     (oe),
    .pe     (pe)
  );

  always #5 fclk = ~fclk;

  initial begin
    forever begin
      @(posedge fclk);
      #1 bclkx8 = ~bclkx8;
    end
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic line_bit(input logic [7:0] data, input logic stop_bit,
                                    input logic par_bit, input int c);
    int idx;
    int b;
    idx = c / 16;
    b   = idx - 1;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return data[b[2:0]];
    if (PAR_BITS == 1 && idx == 9) return par_bit;
    return stop_bit || ((c % 16) >= 8);
  endfunction

  // Return on a negedge whose following posedge carries a tick.
  task automatic align();
    do @(negedge fclk); while (bclkx8 !== 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit,
                            input int abort_bit, input int rd_at);
    align();
    for (int c = 0; c < FRAME_CYCLS; c++) begin
      if (abort_bit >= 0 && c == 16 * (abort_bit + 1) + 8) begin
        rst = 1'b1;
        rxd = 1'b1;
        rd  = 1'b0;
        repeat (2) @(negedge fclk);
        rst = 1'b0;
        @(negedge fclk);
        return;
      end
      rxd = line_bit(data, stop_bit, par_bit, c);
      rd  = (c == rd_at);
      @(negedge fclk);
    end
    rxd = 1'b1;
    rd  = 1'b0;
    @(negedge fclk);
  endtask

  task automatic rd_pulse();
    rd = 1'b1;
    @(negedge fclk);
    rd = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge fclk);
    rst = 1'b0;
    @(negedge fclk);
    chk("rst_dout", dout, 8'h00);
    chk("rst_rdrf", 8'(rdrf), 8'd0);
    chk("rst_fe", 8'(fe), 8'd0);
    chk("rst_oe", 8'(oe), 8'd0);
    chk("rst_pe", 8'(pe), 8'd0);

    send_frame(8'hA5, 1'b1, ^8'hA5, -1, -1);
    chk("a5_dout", dout, 8'hA5);
    chk("a5_rdrf", 8'(rdrf), 8'd1);
    chk("a5_fe", 8'(fe), 8'd0);
    chk("a5_oe", 8'(oe), 8'd0);
    chk("a5_pe", 8'(pe), 8'd0);
    rd_pulse();
    chk("a5_rd_rdrf", 8'(rdrf), 8'd0);

    send_frame(8'h3C, 1'b0, ^8'h3C, -1, -1);
    chk("3c_dout", dout, 8'h3C);
    chk("3c_rdrf", 8'(rdrf), 8'd1);
    chk("3c_fe", 8'(fe), 8'd1);
    rd_pulse();
    chk("3c_rd_fe", 8'(fe), 8'd0);
    chk("3c_rd_rdrf", 8'(rdrf), 8'd0);

    align();
    rxd = 1'b0;
    repeat (4) @(negedge fclk);
    rxd = 1'b1;
    repeat (40) @(negedge fclk);
    chk("glitch_rdrf", 8'(rdrf), 8'd0);
    send_frame(8'h01, 1'b1, ^8'h01, -1, -1);
    chk("01_dout", dout, 8'h01);
    chk("01_rdrf", 8'(rdrf), 8'd1);
    rd_pulse();

    send_frame(8'h11, 1'b1, ^8'h11, -1, -1);
    chk("11_dout", dout, 8'h11);
    chk("11_oe", 8'(oe), 8'd0);
    send_frame(8'h22, 1'b1, ^8'h22, -1, -1);
    chk("ovr_dout", dout, 8'h11);
    chk("ovr_rdrf", 8'(rdrf), 8'd1);
    chk("ovr_oe", 8'(oe), 8'd1);
    rd_pulse();
    chk("ovr_rd_oe", 8'(oe), 8'd0);
    chk("ovr_rd_rdrf", 8'(rdrf), 8'd0);

    send_frame(8'h11, 1'b1, ^8'h11, -1, -1);
    send_frame(8'h22, 1'b1, ^8'h22, -1, LOAD_OFS);
    chk("rdld_dout", dout, 8'h22);
    chk("rdld_rdrf", 8'(rdrf), 8'd1);
    chk("rdld_oe", 8'(oe), 8'd0);

    send_frame(8'h96, 1'b1, ^8'h96, 4, -1);
    chk("abort_dout", dout, 8'h00);
    chk("abort_rdrf", 8'(rdrf), 8'd0);
    chk("abort_fe", 8'(fe), 8'd0);
    chk("abort_oe", 8'(oe), 8'd0);
    chk("abort_pe", 8'(pe), 8'd0);
    send_frame(8'h5A, 1'b1, ^8'h5A, -1, -1);
    chk("5a_dout", dout, 8'h5A);
    chk("5a_rdrf", 8'(rdrf), 8'd1);
    chk("5a_fe", 8'(fe), 8'd0);
    rd_pulse();

`ifdef PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, -1, -1);
    chk("par_ok_dout", dout, 8'h07);
    chk("par_ok_pe", 8'(pe), 8'd0);
    rd_pulse();
    send_frame(8'h07, 1'b1, 1'b0, -1, -1);
    chk("par_bad_dout", dout, 8'h07);
    chk("par_bad_pe", 8'(pe), 8'd1);
    rd_pulse();
    chk("par_rd_pe", 8'(pe), 8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the consuming end of the baud rate generator's 8x oversampling tick. Deserialises an asynchronous 8N1 serial line (optional even parity) into bytes, LSB first, sampling each bit at its centre. Presents each byte in a holding register with a full flag, read strobe, and framing/overrun/parity error flags for the host-side logic.

## Interface
- No parameters. Format is 8 data bits, 1 stop bit; oversampling is fixed at 8 ticks per bit.
- fclk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- bclkx8  input  1  oversample tick enable, one fclk cycle wide, 8 per bit time; logic advances only on cycles where it is 1.
- rxd  input  1  serial line, idle high, asynchronous to fclk.
- rd  input  1  host read strobe, one fclk cycle; acknowledges dout and clears flags.
- dout  output  8  received byte holding register.
- rdrf  output  1  receive data register full.
- fe  output  1  framing error: stop bit sampled 0.
- oe  output  1  overrun: a byte completed while rdrf was 1.
- pe  output  1  parity error (PARITY_EN only; constant 0 otherwise).

## Operation
- rxd passes through a 2-flop synchroniser (both flops reset to 1); all sampling uses the synchronised value rxd_s.
- 3-bit tick counter cnt, 3-bit bit counter bitcnt, 8-bit shift register sr.
- States: IDLE, START, DATA, PARITY (PARITY_EN only), STOP.
- IDLE: on tick with rxd_s=0 -> START, cnt=0.
- START: cnt increments per tick; on the tick where cnt reaches 3 (mid start bit), rxd_s=0 -> DATA with cnt=0 and bitcnt=0; rxd_s=1 -> false start, back to IDLE with no flag change.
- DATA: cnt increments per tick and wraps 7->0; on the tick where cnt=7, shift rxd_s into sr MSB (sr right-shifts, giving LSB-first order) and increment bitcnt. After the 8th bit -> PARITY if PARITY_EN, else STOP.
- PARITY: sample at cnt=7; store pe_next = XOR(sr, rxd_s) (even parity: 1 means error) -> STOP.
- STOP: sample at cnt=7, then perform the load and return to IDLE. The load is:
  - rdrf=0 or rd=1 on the same cycle: dout=sr, rdrf=1, fe=~rxd_s, pe=pe_next.
  - rdrf=1 and rd=0: dout, fe and pe keep their values; the new byte is discarded and oe=1.
- A frame with stop bit 0 still loads dout.
- Next start detection is allowed from the tick after the return to IDLE. An rxd_s low seen on that tick is treated as a start edge.
- rd with no load in the same cycle clears rdrf, fe, pe and oe on the next edge. rd while rdrf=0 has no effect.
- Ticks and rxd changes while bclkx8=0 are ignored, except by the synchroniser.

## Timing
- Reset values: dout=8'h00, rdrf=0, fe=0, oe=0, pe=0, state IDLE, cnt=0, bitcnt=0, sr=0, synchroniser=1.
- rst mid-frame aborts immediately and discards the partial byte. After release, the next start needs a fresh low sample.
- Tick numbering is relative to the detection tick t0:
  - start confirmed at t0+3;
  - data bit k (k=0..7) sampled at t0+3+8(k+1);
  - stop sampled at t0+75 without PARITY_EN, t0+83 with it.
- rdrf/dout/fe/pe/oe update on the fclk edge ending the stop-sample tick cycle (registered, 1-cycle latency).
- Input latency from rxd pin to rxd_s is 2 fclk cycles.

## Configuration
- PARITY_EN defined:
  - PARITY state present; frame is start + 8 data + even parity + stop.
  - pe reports the parity mismatch, with the same load and clear rules as fe.
- PARITY_EN undefined:
  - no PARITY state; frame is 8N1.
  - pe is tied to 0.

## Test plan
- Reset, then send 0xA5 (8N1, exact 8 ticks/bit, 1 idle fclk cycle between ticks) -> dout=8'hA5, rdrf=1, fe=0, oe=0; rd -> rdrf=0 next cycle.
- Send 0x3C with stop bit driven 0 -> dout=8'h3C, rdrf=1, fe=1; rd clears fe.
- Low glitch of 2 ticks on idle line -> returns to IDLE, rdrf stays 0; then 0x01 is received correctly.
- Send 0x11 then 0x22 with no rd -> dout=8'h11, oe=1 after the second stop. Repeat with rd asserted exactly on the second load cycle -> dout=8'h22, rdrf=1, oe=0.
- Assert rst at data bit 4 of a frame -> all outputs return to reset values; the following frame 0x5A is received correctly.
- PARITY_EN: send 0x07 with parity bit 1 -> pe=0; with parity bit 0 -> pe=1, dout=8'h07.
